// File: rtl/iob_eth_mdio.sv
// MDIO/MDC management master: runs one clause-22 read or write frame per accepted request.
// Bit cells are 2*CLK_DIV cycles; MDIO changes as MDC falls and is sampled as MDC rises.
`timescale 1ns/1ps
module iob_eth_mdio #(
    parameter int unsigned CLK_DIV = 20
) (
    input  logic        clk_i,
    input  logic        cke_i,
    input  logic        arst_n_i,
    input  logic        start_i,
    input  logic        rd_i,
    input  logic        no_pre_i,
    input  logic [4:0]  phy_addr_i,
    input  logic [4:0]  reg_addr_i,
    input  logic [15:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] rdata_o,
    output logic        ack_err_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i
);

    localparam int unsigned DivW = $clog2(2 * CLK_DIV);
    localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StPre, StHdr, StTa, StData, StDone} state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [4:0]      bit_q, bit_d;
    logic [31:0]     tx_q, tx_d;
    logic            rd_q, rd_d;
    logic [15:0]     rx_q, rx_d;
    logic            ta2_q, ta2_d;
    logic [15:0]     rdata_q, rdata_d;
    logic            ack_q, ack_d;

    logic       in_frame, rise, cell_end, bit_last;
    logic [4:0] bit_len;

    assign in_frame = (state_q == StPre) || (state_q == StHdr) ||
                      (state_q == StTa)  || (state_q == StData);
    assign rise     = (div_q == DivHalf);
    assign cell_end = (div_q == DivLast);

    always_comb begin
        bit_len = 5'd0;
        case (state_q)
            StPre:   bit_len = 5'd31;
            StHdr:   bit_len = 5'd13;
            StTa:    bit_len = 5'd1;
            StData:  bit_len = 5'd15;
            default: bit_len = 5'd0;
        endcase
    end
    assign bit_last = (bit_q == bit_len);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rd_d    = rd_q;
        rx_d    = rx_q;
        ta2_d   = ta2_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start_i) begin
                    state_d = no_pre_i ? StHdr : StPre;
                    div_d   = '0;
                    bit_d   = '0;
                    rd_d    = rd_i;
                    // ST, OP, PHYAD, REGAD, TA(10), DATA; TA/DATA bits are unused on reads
                    tx_d    = {2'b01, rd_i ? 2'b10 : 2'b01, phy_addr_i, reg_addr_i, 2'b10,
                               wdata_i};
                end
            end
            default: begin
                div_d = div_q + 1'b1;
                if (rise) begin
                    if (state_q == StTa && bit_q == 5'd1) ta2_d = mdio_i;
                    if (state_q == StData) rx_d = {rx_q[14:0], mdio_i};
                end
                if (cell_end) begin
                    div_d = '0;
                    bit_d = bit_q + 1'b1;
                    if (state_q != StPre) tx_d = {tx_q[30:0], 1'b0};
                    if (bit_last) begin
                        bit_d = '0;
                        case (state_q)
                            StPre:  state_d = StHdr;
                            StHdr:  state_d = StTa;
                            StTa:   state_d = StData;
                            StData: begin
                                state_d = StDone;
                                if (rd_q) begin
                                    rdata_d = rx_q;
                                    ack_d   = ta2_q;
                                end
                            end
                            default: state_d = StIdle;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rd_q    <= 1'b0;
            rx_q    <= '0;
            ta2_q   <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            rx_q    <= rx_d;
            ta2_q   <= ta2_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    assign busy_o    = in_frame;
    assign done_o    = (state_q == StDone);
    assign rdata_o   = rdata_q;
    assign ack_err_o = ack_q;
    assign mdc_o     = in_frame && (div_q >= DivHalf);
    // Reads release the bus from the first turnaround bit onwards
    assign mdio_oe_o = (state_q == StPre) || (state_q == StHdr) || (in_frame && !rd_q);
    assign mdio_o    = (mdio_oe_o && state_q != StPre) ? tx_q[31] : 1'b1;

endmodule

// File: doc/iob_eth_mdio.md
# iob_eth_mdio

MDIO/MDC management master for the Ethernet core. It executes one IEEE 802.3 clause-22 read or write frame per request to the external PHY over the two-wire management bus. It sits between the core's MII management registers (MIIMODER, MIICOMMAND, MIIADDRESS, MIITX_DATA, MIIRX_DATA, MIISTATUS) and the PHY pins. The register side supplies a start pulse, an opcode, addresses and write data. The block returns read data, busy/done status and a no-acknowledge flag.

## Interface
- CLK_DIV, 20: clk_i cycles per MDC half-period; legal range is 2 to 255. MDC period is 2*CLK_DIV cycles.
- clk_i  in  1  system clock; the only clock in the block.
- cke_i  in  1  clock enable; when low, all state holds.
- arst_n_i  in  1  asynchronous reset, active-low.
- start_i  in  1  one-cycle request; accepted only when busy_o=0.
- rd_i  in  1  1 = read frame (OP=10), 0 = write frame (OP=01); sampled with start_i.
- no_pre_i  in  1  1 = omit the 32-bit preamble; sampled with start_i.
- phy_addr_i  in  5  PHYAD; sampled with start_i.
- reg_addr_i  in  5  REGAD; sampled with start_i.
- wdata_i  in  16  write data; sampled with start_i.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse at frame end.
- rdata_o  out  16  last read data; holds until the next read completes.
- ack_err_o  out  1  last read saw no PHY acknowledge; holds until the next read completes.
- mdc_o  out  1  management clock to the PHY.
- mdio_o  out  1  MDIO output value.
- mdio_oe_o  out  1  MDIO output enable (1 = drive).
- mdio_i  in  1  MDIO input from the pad.

## Operation
- Reset values: busy_o=0, done_o=0, rdata_o=0, ack_err_o=0, mdc_o=0, mdio_o=1, mdio_oe_o=0, state=IDLE.
- Frame bit order, MSB first:
  - PRE: 32 ones (skipped if no_pre_i=1).
  - ST: 01.
  - OP: 01 for write, 10 for read.
  - PHYAD: 5 bits.
  - REGAD: 5 bits.
  - TA: 2 bits.
  - DATA: 16 bits.
- Frame length: N=64 bits with preamble, N=32 without.
- States: IDLE, PRE, HDR (14 bits ST+OP+PHYAD+REGAD), TA, DATA, DONE.
  - IDLE → PRE on start_i with no_pre_i=0.
  - IDLE → HDR on start_i with no_pre_i=1.
  - PRE → HDR after 32 bits.
  - HDR → TA after 14 bits.
  - TA → DATA after 2 bits.
  - DATA → DONE after 16 bits.
  - DONE → IDLE after one cycle.
- Write frame: mdio_oe_o=1 for the whole frame. TA drives 1 then 0. DATA drives wdata.
- Read frame: mdio_oe_o=1 through REGAD. mdio_oe_o=0 from the first TA bit to frame end.
- Read capture:
  - mdio_i is sampled at each MDC rising edge.
  - At the second TA bit, sample 1 → ack_err_o=1, otherwise 0.
  - The 16 DATA samples shift into rdata_o MSB first.
  - rdata_o and ack_err_o update only in the DONE cycle, and only for read frames.
- Write frames leave rdata_o and ack_err_o unchanged.
- In IDLE: mdc_o=0, mdio_oe_o=0, mdio_o=1.
- start_i while busy_o=1 is ignored; no queuing.
- Request fields are registered at acceptance. Later input changes do not affect the frame in progress.

## Timing
- start_i high in cycle 0 (with busy_o=0):
  - busy_o=1 from cycle 1.
  - First bit is on mdio_o from cycle 1, with mdc_o=0.
- Bit cell, 2*CLK_DIV cycles:
  - mdc_o low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - mdio_o/mdio_oe_o change only in the cycle mdc_o goes low, so data is stable for CLK_DIV cycles before each rising edge.
  - Sampling happens in the cycle mdc_o goes high.
- Frame end:
  - done_o=1 and busy_o=0 in cycle 1+2*CLK_DIV*N.
  - mdc_o=0 and mdio_oe_o=0 in that same cycle.
- Back-to-back: a start_i in the done_o cycle is accepted, and the next frame begins one cycle later.
- arst_n_i low at any time, including mid-frame:
  - All outputs return to their reset values immediately (asynchronous).
  - mdio is released and the partial frame is discarded.
- cke_i low: the divider, bit counter and state freeze, and outputs hold. The frame stretches by the number of stalled cycles.

## Test plan
- Write with preamble, CLK_DIV=4, phy 1, reg 0, data 0x1140:
  - mdio_o sampled on MDC rising edges = 32 ones, then 01 01 00001 00000 10 0001000101000000.
  - done_o 513 cycles after start_i; rdata_o stays 0.
- Read, no_pre_i=1, CLK_DIV=4, phy 3, reg 2:
  - PHY model drives TA2=0 and data 0x0141.
  - mdio_oe_o falls at the first TA bit.
  - done_o at cycle 257; rdata_o=0x0141; ack_err_o=0.
- Read with mdio_i held at 1 (no PHY): rdata_o=0xFFFF, ack_err_o=1; a following write leaves both unchanged.
- start_i pulsed mid-frame with different fields: ignored, the frame in progress is bit-exact, and there is exactly one done_o.
- arst_n_i pulsed low during DATA of a write: outputs go to reset values immediately; a new start afterwards produces a complete, correct frame.
- cke_i held low for 10 cycles mid-HDR: mdc_o/mdio_o frozen; done_o delayed by exactly 10 cycles; bit sequence unchanged.
